// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller:
// scan state enum, the all-off segment pattern and the hex glyph set
// (segment order gfedcba, active-low).
package seg7_pkg;

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg7dec.sv
// Hex nibble to active-low 7-segment glyph decoder (gfedcba).
module seg7dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure lookup of the glyph for one nibble.
    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller. Each digit gets PRESCALE cycles,
// the first GAP of which are blanked to avoid ghosting. A loaded value is
// held pending and only enters the shadow (displayed) register at the frame
// boundary, so a frame never shows a mix of old and new digits.
// Optional macro SEG7_SCAN_BLANK_EN: blank leading zeros (digit 0 never).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GAP      = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic                  LOAD,
    output logic                  PEND,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME
);

    localparam int CW = $clog2(PRESCALE);
    localparam int DW = $clog2(DIGITS);

    logic [CW-1:0]            c, c_nx;
    logic [DW-1:0]            d, d_nx;
    state_t                   state, state_nx;
    logic                     boundary;
    logic [DIGITS-1:0][3:0]   pend_q, shadow;
    logic [3:0]               nib;
    logic [6:0]               glyph;
    logic                     lead_zero;
    logic [6:0]               seg_nx;
    logic [DIGITS-1:0]        an_nx;

    // Slot/digit counters and scan state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            c     <= '0;
            d     <= '0;
            state <= BLANK;
        end else begin
            c     <= c_nx;
            d     <= d_nx;
            state <= state_nx;
        end
    end

    // Next counter values, state (derived from the next slot count) and
    // the output pattern for the current slot.
    always_comb begin
        boundary = (c == CW'(PRESCALE-1)) && (d == DW'(DIGITS-1));
        c_nx     = c + 1'b1;
        d_nx     = d;
        if (c == CW'(PRESCALE-1)) begin
            c_nx = '0;
            d_nx = (d == DW'(DIGITS-1)) ? '0 : d + 1'b1;
        end
        state_nx = (c_nx < CW'(GAP)) ? BLANK : SHOW;

        seg_nx = SEG_OFF;
        an_nx  = '1;
        if (state == SHOW) begin
            an_nx[d] = 1'b0;
            seg_nx   = lead_zero ? SEG_OFF : glyph;
        end
    end

    // One decoder shared by all digits.
    assign nib = shadow[d];

    seg7dec u_dec (
        .nib (nib),
        .seg (glyph)
    );

`ifdef SEG7_SCAN_BLANK_EN
    // Digit d>0 is a leading zero when it and every higher nibble are zero.
    always_comb begin
        lead_zero = (d != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(d) && shadow[i] != 4'h0)
                lead_zero = 1'b0;
        end
    end
`else
    assign lead_zero = 1'b0;
`endif

    // Registered display outputs and frame pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SEG   <= SEG_OFF;
            AN    <= '1;
            FRAME <= 1'b0;
        end else begin
            SEG   <= seg_nx;
            AN    <= an_nx;
            FRAME <= boundary;
        end
    end

    // Pending/shadow handoff: a load at the boundary bypasses the pending
    // register; otherwise a pending value is promoted at the boundary.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q <= '0;
            shadow <= '0;
            PEND   <= 1'b0;
        end else if (boundary) begin
            if (LOAD)
                shadow <= VALUE;
            else if (PEND)
                shadow <= pend_q;
            PEND <= 1'b0;
        end else if (LOAD) begin
            pend_q <= VALUE;
            PEND   <= 1'b1;
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed 7-segment digits, range 2..8.
REQ-002 SHALL have parameter PRESCALE, default 50000: CLK cycles per digit slot, minimum 4.
REQ-003 SHALL have parameter GAP, default 2: blanked cycles at slot start (anti-ghosting), 1..PRESCALE-2.
REQ-004 SHALL have port CLK  input  1: the block's one clock; all state changes on its rising edge.
REQ-005 SHALL have port RST  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port VALUE  input  4*DIGITS: hex nibbles; VALUE[3:0] is digit 0, the least significant digit.
REQ-007 SHALL have port LOAD  input  1: single-cycle request to capture VALUE.
REQ-008 SHALL have port PEND  output  1: captured value is waiting for the frame boundary.
REQ-009 SHALL have port SEG  output  7: segments gfedcba, active-low (0 = lit).
REQ-010 SHALL have port AN  output  DIGITS: digit enables, active-low, at most one bit low.
REQ-011 SHALL have port FRAME  output  1: one-cycle pulse per completed scan frame.

Function
REQ-012 SHALL hold slot counter c (0..PRESCALE-1) and digit index d (0..DIGITS-1); c increments every cycle; at c=PRESCALE-1, c wraps to 0 and d increments, wrapping DIGITS-1 to 0.
REQ-013 SHALL use two states: BLANK while c<GAP, SHOW while c>=GAP.
REQ-014 SHALL register SEG, AN and FRAME: values output in cycle n+1 reflect c, d and state in cycle n.
REQ-015 In BLANK, SHALL drive SEG=7'h7F and AN all ones.
REQ-016 In SHOW, SHALL drive AN with only bit d low and SEG with the decode of shadow nibble d.
REQ-017 Decode SHALL map 0..F to the team's standard active-low hex glyphs, e.g. 0->1000000, 8->0000000, F->0001110.
REQ-018 On LOAD, SHALL capture VALUE into a pending register and set PEND; a later LOAD before the boundary overwrites the pending register.
REQ-019 At the frame boundary (c=PRESCALE-1, d=DIGITS-1), if PEND is set, SHALL copy the pending register to the shadow register and clear PEND.
REQ-020 If LOAD coincides with the boundary, SHALL write VALUE directly into the shadow register and leave PEND clear.
REQ-021 The shadow register SHALL change only at frame boundaries, so a digit never changes mid-frame.
REQ-022 SHALL pulse FRAME for exactly one cycle, registered from the boundary cycle.

Reset
REQ-023 While RST is high, SHALL set SEG=7'h7F, AN all ones, FRAME=0, PEND=0, c=0, d=0, state BLANK, and pending and shadow registers to zero.
REQ-024 RST asserted mid-slot SHALL abort the scan and discard any pending load; after release, scanning SHALL restart at digit 0, c=0.

Configuration
REQ-025 With macro SEG7_SCAN_BLANK_EN defined, SHALL blank leading zeros: during SHOW, digit d>0 outputs SEG=7'h7F with AN still driven when all shadow nibbles d..DIGITS-1 are zero.
REQ-026 Digit 0 SHALL never be blanked, so value 0 displays as a single 0.
REQ-027 Without SEG7_SCAN_BLANK_EN, SHALL display every digit, including leading zeros.

Structure
REQ-028 Package seg7_pkg SHALL hold the state enum (BLANK, SHOW), constant SEG_OFF=7'h7F, and the hex glyph constants.
REQ-029 The decode SHALL be one shared instance of sub-module seg7dec, fed by a nibble multiplexer selecting digit d.

Verification (DIGITS=4, PRESCALE=8, GAP=2)
REQ-030 Release RST -> cycles 0-2 show AN=1111 and SEG=1111111; cycle 3 shows AN=1110, SEG=1000000; AN=1101 from cycle 11.
REQ-031 LOAD with VALUE=16'h1234 mid-frame -> PEND=1 until the boundary; the next frame shows 4,3,2,1 (0011001, 0110000, 0100100, 1111001); FRAME pulses once every 32 cycles.
REQ-032 LOAD with VALUE=16'hABCD in the boundary cycle -> PEND stays 0; the following frame shows D,C,B,A.
REQ-033 Two LOADs in one frame (16'h1111 then 16'h2222) -> only 2222 is displayed.
REQ-034 SEG7_SCAN_BLANK_EN defined, VALUE=16'h0050 -> digits 3 and 2 show SEG=1111111, digit 1 shows 0010010, digit 0 shows 1000000; undefined -> digits 3 and 2 show 1000000.
REQ-035 RST pulsed during a SHOW slot with PEND=1 -> the next cycle has SEG=7'h7F and AN=1111, and PEND=0.
